// File: rtl/mr1_data_bus_slave_if.sv
// MR1 data bus: split request/response channel between core and memory.
// Request side is valid/ready; response side is valid-only, in order.
interface mr1_data_bus_slave_if;
    logic        data_req_valid;
    logic        data_req_ready;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;

    modport master (
        output data_req_valid,
        output data_req_wr,
        output data_req_size,
        output data_req_addr,
        output data_req_data,
        input  data_req_ready,
        input  data_rsp_valid,
        input  data_rsp_data
    );

    modport slave (
        input  data_req_valid,
        input  data_req_wr,
        input  data_req_size,
        input  data_req_addr,
        input  data_req_data,
        output data_req_ready,
        output data_rsp_valid,
        output data_rsp_data
    );
endinterface

// File: rtl/mr1_data_bus_slave.sv
// MR1 data-side memory responder: word RAM, byte/half/word writes,
// fixed-latency in-order reads, bounded outstanding reads, misalign flag.
module mr1_data_bus_slave #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RSP_LATENCY     = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mr1_data_bus_slave_if.slave   bus,
    input  logic                  req_stall,
    output logic                  misalign_err,
    output logic [3:0]            outstanding
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned L  = RSP_LATENCY;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          accept;
    logic          rd_acc;
    logic          wr_acc;
    logic          mis;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [L-1:0]  vld;
    logic [31:0]   dat [L];
    logic          unused_addr;

    assign idx         = bus.data_req_addr[AW+1:2];
    assign unused_addr = ^bus.data_req_addr[31:AW+2];

    assign bus.data_req_ready =
        !req_stall && (outstanding < 4'(MAX_OUTSTANDING));

    assign accept = bus.data_req_valid && bus.data_req_ready;
    assign rd_acc = accept && !bus.data_req_wr;
    assign wr_acc = accept && bus.data_req_wr && !mis;

    always_comb begin
        mis   = 1'b1;
        be    = 4'b0000;
        wdata = bus.data_req_data;
        unique case (bus.data_req_size)
            2'd0: begin
                mis   = 1'b0;
                be    = 4'b0001 << bus.data_req_addr[1:0];
                wdata = {4{bus.data_req_data[7:0]}};
            end
            2'd1: begin
                mis   = bus.data_req_addr[0];
                be    = bus.data_req_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.data_req_data[15:0]}};
            end
            2'd2: begin
                mis   = |bus.data_req_addr[1:0];
                be    = 4'b1111;
            end
            default: begin
                mis   = 1'b1;
            end
        endcase
    end

    // Read data is sampled combinationally at acceptance; misaligned reads return 0.
    assign rd_word = mis ? 32'h0 : mem[idx];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Data in each stage only moves with a valid, so the last stage holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld          <= '0;
            misalign_err <= 1'b0;
            outstanding  <= 4'd0;
            for (int i = 0; i < int'(L); i++) begin
                dat[i] <= 32'h0;
            end
        end else begin
            vld[0] <= rd_acc;
            if (rd_acc) begin
                dat[0] <= rd_word;
            end
            for (int i = 1; i < int'(L); i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
            misalign_err <= accept && mis;
            outstanding  <= outstanding + {3'b000, rd_acc}
                          - {3'b000, vld[L-1]};
        end
    end

    assign bus.data_rsp_valid = vld[L-1];
    assign bus.data_rsp_data  = dat[L-1];
endmodule

// File: tb/tb_mr1_data_bus_slave.sv
// Self-checking bench for mr1_data_bus_slave: directed scenarios plus
// randomized traffic against a byte-addressed memory / response-queue model.
module tb_mr1_data_bus_slave;
    localparam int LAT   = 2;
    localparam int MAXO  = 2;
    localparam int WORDS = 1024;

    typedef struct {
        int unsigned due;
        logic [31:0] d;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       mis;
    logic [3:0] outst;

    always #5 clk = ~clk;

    mr1_data_bus_slave_if bus();

    mr1_data_bus_slave #(
        .MEM_WORDS(WORDS),
        .RSP_LATENCY(LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus),
        .req_stall(stall),
        .misalign_err(mis),
        .outstanding(outst)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    rsp_t        q[$];
    logic [31:0] held = '0;
    logic        mis_exp = 1'b0;
    logic [7:0]  m [4096];

    logic        acc_now = 1'b0;
    logic        acc_prev = 1'b0;
    int unsigned acc_cyc = 0;
    logic        mis_post = 1'b0;
    logic [31:0] rsp_log[$];
    int unsigned rsp_cyc[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic bad(logic [1:0] sz, logic [31:0] ad);
        return (sz == 2'd3) || (sz == 2'd1 && ad[0]) ||
               (sz == 2'd2 && ad[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] mword(logic [31:0] ad);
        int b;
        b = int'(ad[11:2]) * 4;
        return {m[b+3], m[b+2], m[b+1], m[b]};
    endfunction

    task automatic mwrite(logic [1:0] sz, logic [31:0] ad, logic [31:0] dt);
        int b;
        b = int'(ad[11:2]) * 4;
        case (sz)
            2'd0: m[b + int'(ad[1:0])] = dt[7:0];
            2'd1: begin
                m[b + (ad[1] ? 2 : 0)]     = dt[7:0];
                m[b + (ad[1] ? 2 : 0) + 1] = dt[15:8];
            end
            default: for (int i = 0; i < 4; i++) m[b+i] = dt[8*i +: 8];
        endcase
    endtask

    // One clock cycle: check outputs at negedge, advance the model at posedge.
    task automatic tick();
        logic        rdy_e, rv_e, a, wr;
        logic [31:0] rd_e, ad, dt;
        logic [1:0]  sz;
        @(negedge clk);
        rdy_e = !stall && (q.size() < MAXO);
        rv_e  = (q.size() > 0) && (q[0].due == cyc);
        rd_e  = rv_e ? q[0].d : held;
        if (rst_n) begin
            chk("ready", {31'b0, bus.data_req_ready}, {31'b0, rdy_e});
            chk("rsp_valid", {31'b0, bus.data_rsp_valid}, {31'b0, rv_e});
            chk("rsp_data", bus.data_rsp_data, rd_e);
            chk("misalign_err", {31'b0, mis}, {31'b0, mis_exp});
            chk("outstanding", {28'b0, outst}, q.size());
            chk("out_bound", {31'b0, (outst <= 4'(MAXO))}, 32'd1);
        end
        wr = bus.data_req_wr;
        sz = bus.data_req_size;
        ad = bus.data_req_addr;
        dt = bus.data_req_data;
        a  = rst_n && bus.data_req_valid && rdy_e;
        acc_now = a;
        if (a) acc_cyc = cyc;
        if (acc_prev) mis_post = mis;
        acc_prev = a;
        if (bus.data_rsp_valid === 1'b1) begin
            rsp_log.push_back(bus.data_rsp_data);
            rsp_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            held    = '0;
            mis_exp = 1'b0;
        end else begin
            if (rv_e) begin
                held = q[0].d;
                void'(q.pop_front());
            end
            mis_exp = a && bad(sz, ad);
            if (a && wr && !bad(sz, ad)) mwrite(sz, ad, dt);
            else if (a && !wr)
                q.push_back('{due: cyc + LAT, d: bad(sz, ad) ? 32'h0 : mword(ad)});
        end
        cyc++;
        #1;
    endtask

    task automatic req(logic wr, logic [1:0] sz, logic [31:0] ad, logic [31:0] dt);
        bus.data_req_valid = 1'b1;
        bus.data_req_wr    = wr;
        bus.data_req_size  = sz;
        bus.data_req_addr  = ad;
        bus.data_req_data  = dt;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (acc_now) break;
        end
        if (!acc_now) chk("req_timeout", 32'd0, 32'd1);
        bus.data_req_valid = 1'b0;
    endtask

    task automatic rd(logic [1:0] sz, logic [31:0] ad,
                      output logic [31:0] d, output int lat);
        int          n0;
        int unsigned a0;
        n0 = rsp_log.size();
        req(1'b0, sz, ad, 32'h0);
        a0 = acc_cyc;
        for (int k = 0; k < 12; k++) begin
            if (rsp_log.size() > n0) break;
            tick();
        end
        if (rsp_log.size() > n0) begin
            d   = rsp_log[n0];
            lat = int'(rsp_cyc[n0] - a0);
        end else begin
            chk("rsp_timeout", 32'd0, 32'd1);
            d   = 32'hx;
            lat = -1;
        end
    endtask

    logic [31:0] d;
    int          lat, n0;
    int unsigned a1, a2, a3, c0;

    initial begin
        bus.data_req_valid = 1'b0;
        bus.data_req_wr    = 1'b0;
        bus.data_req_size  = 2'd2;
        bus.data_req_addr  = '0;
        bus.data_req_data  = '0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rsp_valid", {31'b0, bus.data_rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.data_rsp_data, 32'd0);
        chk("rst_outstanding", {28'b0, outst}, 32'd0);
        chk("rst_misalign", {31'b0, mis}, 32'd0);

        req(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        rd(2'd2, 32'h10, d, lat);
        chk("word_rd_data", d, 32'hDEADBEEF);
        chk("word_rd_lat", lat, LAT);
        chk("word_rd_out_after", {28'b0, outst}, 32'd0);

        req(1'b1, 2'd2, 32'h0, 32'h0);
        req(1'b1, 2'd0, 32'h2, 32'h000000AA);
        req(1'b1, 2'd1, 32'h0, 32'h00001234);
        rd(2'd2, 32'h0, d, lat);
        chk("merge_data", d, 32'h00AA1234);

        req(1'b1, 2'd2, 32'h4, 32'h55667788);
        req(1'b1, 2'd2, 32'h8, 32'h99AABBCC);
        n0 = rsp_log.size();
        req(1'b0, 2'd2, 32'h0, 32'h0); a1 = acc_cyc;
        req(1'b0, 2'd2, 32'h4, 32'h0); a2 = acc_cyc;
        req(1'b0, 2'd2, 32'h8, 32'h0); a3 = acc_cyc;
        for (int k = 0; k < 10 && rsp_log.size() < n0 + 3; k++) tick();
        chk("b2b_gap12", a2 - a1, 32'd1);
        chk("b2b_gap13", a3 - a1, 32'd3);
        chk("b2b_count", rsp_log.size() - n0, 32'd3);
        if (rsp_log.size() >= n0 + 3) begin
            chk("b2b_d0", rsp_log[n0],     32'h00AA1234);
            chk("b2b_d1", rsp_log[n0 + 1], 32'h55667788);
            chk("b2b_d2", rsp_log[n0 + 2], 32'h99AABBCC);
            chk("b2b_c1", rsp_cyc[n0 + 1] - rsp_cyc[n0], 32'd1);
            chk("b2b_c2", rsp_cyc[n0 + 2] - a1, 32'(LAT + 3));
        end

        req(1'b1, 2'd2, 32'h6, 32'hFFFFFFFF);
        tick();
        chk("mis_wr_pulse", {31'b0, mis_post}, 32'd1);
        rd(2'd2, 32'h4, d, lat);
        chk("mis_wr_noeffect", d, 32'h55667788);
        chk("aligned_no_pulse", {31'b0, mis_post}, 32'd0);
        rd(2'd1, 32'h3, d, lat);
        chk("mis_rd_data", d, 32'h0);
        chk("mis_rd_pulse", {31'b0, mis_post}, 32'd1);

        stall = 1'b1;
        bus.data_req_valid = 1'b1;
        bus.data_req_wr    = 1'b1;
        bus.data_req_size  = 2'd2;
        bus.data_req_addr  = 32'h14;
        bus.data_req_data  = 32'h0BADCAFE;
        repeat (3) begin
            tick();
            chk("bp_no_accept", {31'b0, acc_now}, 32'd0);
        end
        stall = 1'b0;
        c0 = cyc;
        req(1'b1, 2'd2, 32'h14, 32'h0BADCAFE);
        chk("bp_first_accept", acc_cyc - c0, 32'd0);
        rd(2'd2, 32'h14, d, lat);
        chk("bp_data", d, 32'h0BADCAFE);

        req(1'b1, 2'd2, 32'h100, 32'hCAFEF00D);
        n0 = rsp_log.size();
        req(1'b0, 2'd2, 32'h10, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rst_dropped", rsp_log.size() - n0, 32'd0);
        chk("rst_out_zero", {28'b0, outst}, 32'd0);
        rd(2'd2, 32'h100, d, lat);
        chk("ram_kept", d, 32'hCAFEF00D);

        for (int i = 0; i < 16; i++) req(1'b1, 2'd2, 32'(i * 4), $urandom);
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 4) == 0;
            bus.data_req_valid = $urandom % 2;
            bus.data_req_wr    = $urandom % 2;
            bus.data_req_size  = 2'($urandom % 4);
            bus.data_req_addr  = ($urandom & 32'hFFFF_F000) |
                                 32'($urandom_range(0, 63));
            bus.data_req_data  = $urandom;
            tick();
        end
        stall = 1'b0;
        bus.data_req_valid = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mr1_data_bus_slave.md
Name: mr1_data_bus_slave

Overview:
- Data-side memory responder for the MR1 core's split request/response data bus; sits directly downstream of the core's data_req_* port and drives data_rsp_*.
- Word-addressed RAM with byte/half/word writes and fixed-latency, in-order read responses.
- Bounded outstanding-read count and injectable backpressure, so the core's stall and handshake paths are exercised in simulation and formal runs.
- Flags misaligned accesses instead of trapping.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two; index = addr[log2(MEM_WORDS)+1:2], upper bits ignored (wrap).
- RSP_LATENCY, 2, cycles from read acceptance to data_rsp_valid; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum accepted reads not yet responded; legal range 1..RSP_LATENCY.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- data_req_valid  in  1  core request valid
- data_req_ready  out  1  slave can accept this cycle
- data_req_wr  in  1  1 = write, 0 = read
- data_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as misaligned
- data_req_addr  in  32  byte address
- data_req_data  in  32  write data, right-justified (byte in [7:0], half in [15:0])
- data_rsp_valid  out  1  read response valid, one cycle
- data_rsp_data  out  32  full aligned RAM word; the core extracts lanes
- req_stall  in  1  bench backpressure injection; forces ready low
- misalign_err  out  1  one-cycle pulse on acceptance of a misaligned request
- outstanding  out  4  current count of in-flight reads

Behaviour:
- Reset (reset==0 at posedge):
  - data_rsp_valid=0, data_rsp_data=0, misalign_err=0, outstanding=0.
  - Delay pipeline is cleared; any in-flight reads are dropped with no response.
  - RAM contents are not reset.
- Handshake:
  - data_req_ready = !req_stall && (outstanding < MAX_OUTSTANDING). Ready is combinational and does not depend on data_req_valid.
  - Accept = valid && ready. At most one accept per cycle.
  - Valid asserted while ready is low: request held by the core; no state change.
- Alignment:
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size==3.
  - On acceptance, misalign_err pulses in the following cycle.
  - A misaligned write does not modify RAM.
  - A misaligned read still produces a response, with data 0.
- Write, accepted in cycle N: RAM updated at the posedge ending N.
  - Byte: data[7:0] written to lane addr[1:0].
  - Half: data[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Writes produce no response and do not count as outstanding.
- Read, accepted in cycle N:
  - RAM word sampled at acceptance; it reflects all writes accepted in earlier cycles.
  - The word enters a RSP_LATENCY-deep valid+data shift register.
  - data_rsp_valid=1 and data_rsp_data=word in cycle N+RSP_LATENCY, for exactly one cycle.
  - When data_rsp_valid=0, data_rsp_data holds its last value.
- Ordering: responses are strictly in acceptance order; at most one per cycle, guaranteed by the single accept per cycle.
- Outstanding counter:
  - +1 on read accept; -1 when data_rsp_valid is emitted.
  - Read accept and response in the same cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows; assertions in the bench enforce both.
- No response backpressure: the core must sink data_rsp_valid whenever it is asserted.
- Reset mid-operation: pending responses are discarded. The first request after reset release may be accepted in the cycle following the release.

Test Plan:
- Word write then read: write addr 0x10 data 0xDEADBEEF, then read 0x10 -> data_rsp_valid exactly 2 cycles after read accept, data 0xDEADBEEF, outstanding 1->0.
- Byte/half merge: write word 0x0 = 0x00000000, byte 0xAA at 0x2, half 0x1234 at 0x0 -> read 0x0 returns 0x00AA1234.
- Back-to-back reads, MAX_OUTSTANDING=2, RSP_LATENCY=2: valid held for reads 0x0, 0x4, 0x8 -> ready drops after 2 accepts and recovers the cycle a response retires; responses in order, one per cycle.
- Misaligned: word write at 0x6 -> misalign_err pulse, RAM at 0x4 unchanged; half read at 0x3 -> response data 0, misalign_err pulse.
- Backpressure: req_stall high for 3 cycles with valid held -> no accept, no state change; accept on the first cycle stall drops.
- Reset mid-flight: read accepted, reset=0 the next cycle -> no data_rsp_valid ever appears for that read, outstanding=0; write at 0x100 before reset is readable after reset.
